// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate boundaries,
// a clock-enable prescaler, boundary pulses and a sticky error flag.

module counter_updown_param #(
    parameter int unsigned       WIDTH    = 16,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                SAT_MODE = 1'b0,
    parameter int unsigned       PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    input  logic             ackErr,
    output logic [WIDTH-1:0] A_count,
    output logic             oFlow,
    output logic             uFlow,
    output logic             errFlag,
    output logic             atMax,
    output logic             atZero
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PsW-1:0]   ps_q, ps_d;
    logic             oflow_q, oflow_d;
    logic             uflow_q, uflow_d;
    logic             err_q, err_d;

    logic dir_valid;
    logic qual;
    logic tick;

    // up=down=1 is treated as no request, same as up=down=0.
    assign dir_valid = up ^ down;
    assign qual      = enable & dir_valid;
    assign tick      = qual & (ps_q == PsLast);

    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        oflow_d = 1'b0;
        uflow_d = 1'b0;
        if (load) begin
            count_d = (dataIn > MAX_VAL) ? MAX_VAL : dataIn;
            ps_d    = '0;
        end else if (qual) begin
            if (tick) begin
                ps_d = '0;
                if (up) begin
                    if (count_q == MAX_VAL) begin
                        oflow_d = 1'b1;
                        count_d = SAT_MODE ? MAX_VAL : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        uflow_d = 1'b1;
                        count_d = SAT_MODE ? '0 : MAX_VAL;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                // Partial prescale is kept across idle cycles; only load or reset clear it.
                ps_d = ps_q + PsW'(1);
            end
        end
    end

    // A new boundary event wins over a same-edge acknowledge.
    always_comb begin
        err_d = err_q;
        if (oflow_d || uflow_d) begin
            err_d = 1'b1;
        end else if (ackErr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            count_q <= '0;
            ps_q    <= '0;
            oflow_q <= 1'b0;
            uflow_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            oflow_q <= oflow_d;
            uflow_q <= uflow_d;
            err_q   <= err_d;
        end
    end

    assign A_count = count_q;
    assign oFlow   = oflow_q;
    assign uFlow   = uflow_q;
    assign errFlag = err_q;
    assign atMax   = (count_q == MAX_VAL);
    assign atZero  = (count_q == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: three configurations (wrap, saturate, prescale-3) driven
// with shared stimulus, checked against a behavioural model plus hand-derived vectors.

module tb_counter_updown_param;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic       CLK = 1'b0;
    logic       clear;
    logic [7:0] din;
    logic       load, enable, up, down, ackErr;

    logic [3:0] cnt_w, cnt_s;
    logic [7:0] cnt_p;
    logic [2:0] of_v, uf_v, err_v, amax_v, azero_v;
    logic [7:0] cnt_v [3];

    always #5 CLK = ~CLK;

    counter_updown_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .PRESCALE(1)
    ) u_wrap (
        .CLK(CLK), .clear(clear), .dataIn(din[3:0]), .load(load), .enable(enable),
        .up(up), .down(down), .ackErr(ackErr), .A_count(cnt_w), .oFlow(of_v[0]),
        .uFlow(uf_v[0]), .errFlag(err_v[0]), .atMax(amax_v[0]), .atZero(azero_v[0])
    );

    counter_updown_param #(
        .WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b1), .PRESCALE(1)
    ) u_sat (
        .CLK(CLK), .clear(clear), .dataIn(din[3:0]), .load(load), .enable(enable),
        .up(up), .down(down), .ackErr(ackErr), .A_count(cnt_s), .oFlow(of_v[1]),
        .uFlow(uf_v[1]), .errFlag(err_v[1]), .atMax(amax_v[1]), .atZero(azero_v[1])
    );

    counter_updown_param #(
        .WIDTH(8), .MAX_VAL(8'd255), .SAT_MODE(1'b0), .PRESCALE(3)
    ) u_pre (
        .CLK(CLK), .clear(clear), .dataIn(din), .load(load), .enable(enable),
        .up(up), .down(down), .ackErr(ackErr), .A_count(cnt_p), .oFlow(of_v[2]),
        .uFlow(uf_v[2]), .errFlag(err_v[2]), .atMax(amax_v[2]), .atZero(azero_v[2])
    );

    assign cnt_v[0] = {4'b0, cnt_w};
    assign cnt_v[1] = {4'b0, cnt_s};
    assign cnt_v[2] = cnt_p;

    typedef struct {
        int cnt;
        int ps;
        bit of;
        bit uf;
        bit err;
    } mst_t;

    typedef struct {
        int inst;
        int cnt;
        bit of;
        bit uf;
        bit err;
        bit amax;
        bit azero;
    } exp_t;

    typedef struct {
        bit         ld;
        logic [7:0] din;
        bit         en;
        bit         up;
        bit         dn;
        bit         ack;
        int         cnt;
        bit         of;
        bit         uf;
        bit         err;
    } vec_t;

    mst_t m [3];
    exp_t sb [$];
    vec_t tbl [16];
    int   errors = 0;
    int   checks = 0;

    function automatic int max_of(input int i);
        return (i == 2) ? 255 : 9;
    endfunction

    function automatic mst_t mstep(input mst_t s, input int i, input bit ld, input int d,
                                   input bit en, input bit u, input bit dn, input bit ack);
        mst_t n;
        int   maxv;
        int   pre;
        int   dm;
        bit   sat;
        maxv = max_of(i);
        pre  = (i == 2) ? 3 : 1;
        sat  = (i == 1);
        dm   = (i == 2) ? d : d % 16;
        n    = s;
        n.of = 1'b0;
        n.uf = 1'b0;
        if (ld) begin
            n.cnt = (dm > maxv) ? maxv : dm;
            n.ps  = 0;
        end else if (en && (u != dn)) begin
            if (s.ps == pre - 1) begin
                n.ps = 0;
                if (u) begin
                    if (s.cnt == maxv) begin
                        n.of  = 1'b1;
                        n.cnt = sat ? maxv : 0;
                    end else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == 0) begin
                        n.uf  = 1'b1;
                        n.cnt = sat ? 0 : maxv;
                    end else n.cnt = s.cnt - 1;
                end
            end else n.ps = s.ps + 1;
        end
        if (n.of || n.uf) n.err = 1'b1;
        else if (ack) n.err = 1'b0;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{cnt: 0, ps: 0, of: 1'b0, uf: 1'b0, err: 1'b0};
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), 32'(cnt_v[i]), 0);
            chk($sformatf("%s_of%0d", tag, i), 32'(of_v[i]), 0);
            chk($sformatf("%s_uf%0d", tag, i), 32'(uf_v[i]), 0);
            chk($sformatf("%s_err%0d", tag, i), 32'(err_v[i]), 0);
            chk($sformatf("%s_zero%0d", tag, i), 32'(azero_v[i]), 1);
            chk($sformatf("%s_max%0d", tag, i), 32'(amax_v[i]), 0);
        end
    endtask

    // Drive one cycle, push model expectations, then pop and compare after the edge.
    task automatic cycle(input bit ld, input logic [7:0] d, input bit en, input bit u,
                         input bit dn, input bit ack);
        exp_t e;
        load   = ld;
        din    = d;
        enable = en;
        up     = u;
        down   = dn;
        ackErr = ack;
        for (int i = 0; i < 3; i++) begin
            m[i] = mstep(m[i], i, ld, int'(d), en, u, dn, ack);
            sb.push_back('{inst: i, cnt: m[i].cnt, of: m[i].of, uf: m[i].uf, err: m[i].err,
                           amax: (m[i].cnt == max_of(i)), azero: (m[i].cnt == 0)});
        end
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("cnt%0d", e.inst), 32'(cnt_v[e.inst]), 32'(e.cnt));
            chk($sformatf("of%0d", e.inst), 32'(of_v[e.inst]), 32'(e.of));
            chk($sformatf("uf%0d", e.inst), 32'(uf_v[e.inst]), 32'(e.uf));
            chk($sformatf("err%0d", e.inst), 32'(err_v[e.inst]), 32'(e.err));
            chk($sformatf("max%0d", e.inst), 32'(amax_v[e.inst]), 32'(e.amax));
            chk($sformatf("zero%0d", e.inst), 32'(azero_v[e.inst]), 32'(e.azero));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // ld din en up dn ack | wrap-instance cnt of uf err
        tbl[0]  = '{T, 8'd8,  F, F, F, F, 8, F, F, F};
        tbl[1]  = '{F, 8'd0,  T, T, F, F, 9, F, F, F};
        tbl[2]  = '{F, 8'd0,  T, T, F, F, 0, T, F, T};
        tbl[3]  = '{F, 8'd0,  T, T, F, F, 1, F, F, T};
        tbl[4]  = '{T, 8'd0,  F, F, F, F, 0, F, F, T};
        tbl[5]  = '{F, 8'd0,  T, F, T, F, 9, F, T, T};
        tbl[6]  = '{F, 8'd0,  F, F, F, T, 9, F, F, F};
        tbl[7]  = '{T, 8'd0,  F, F, F, F, 0, F, F, F};
        tbl[8]  = '{F, 8'd0,  T, F, T, T, 9, F, T, T};
        tbl[9]  = '{T, 8'd9,  F, F, F, F, 9, F, F, T};
        tbl[10] = '{T, 8'd3,  T, T, F, F, 3, F, F, T};
        tbl[11] = '{T, 8'd15, F, F, F, F, 9, F, F, T};
        tbl[12] = '{F, 8'd0,  T, T, F, F, 0, T, F, T};
        tbl[13] = '{F, 8'd0,  T, T, F, F, 1, F, F, T};
        tbl[14] = '{F, 8'd0,  T, T, T, F, 1, F, F, T};
        tbl[15] = '{F, 8'd0,  F, F, F, T, 1, F, F, F};

        clear  = 1'b0;
        din    = '0;
        load   = 1'b0;
        enable = 1'b0;
        up     = 1'b0;
        down   = 1'b0;
        ackErr = 1'b0;
        model_reset();
        #2;
        check_reset_state("rst");
        #10;
        clear = 1'b1;

        for (int k = 0; k < 16; k++) begin
            cycle(tbl[k].ld, tbl[k].din, tbl[k].en, tbl[k].up, tbl[k].dn, tbl[k].ack);
            chk($sformatf("tbl%0d_cnt", k), 32'(cnt_w), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_of", k), 32'(of_v[0]), 32'(tbl[k].of));
            chk($sformatf("tbl%0d_uf", k), 32'(uf_v[0]), 32'(tbl[k].uf));
            chk($sformatf("tbl%0d_err", k), 32'(err_v[0]), 32'(tbl[k].err));
            if (k == 11) chk("sat_clamp_atmax", 32'(amax_v[1]), 1);
            if (k == 12 || k == 13) chk("sat_of_pulse", 32'({cnt_s, of_v[1]}), 32'({4'd9, 1'b1}));
        end

        // Prescale by 3 with two enable-low cycles in the middle: 7 qualifying cycles.
        cycle(T, 8'd10, F, F, F, F);
        cycle(F, 8'd0, T, T, F, F);
        cycle(F, 8'd0, T, T, F, F);
        cycle(F, 8'd0, F, T, F, F);
        cycle(F, 8'd0, F, T, F, F);
        cycle(F, 8'd0, T, T, F, F);
        chk("pre_first_tick", 32'(cnt_p), 11);
        for (int k = 0; k < 4; k++) cycle(F, 8'd0, T, T, F, F);
        chk("pre_after7", 32'(cnt_p), 12);
        cycle(F, 8'd0, T, T, T, F);
        cycle(F, 8'd0, T, T, T, F);
        cycle(F, 8'd0, T, T, F, F);
        chk("pre_frozen_hold", 32'(cnt_p), 12);
        cycle(F, 8'd0, T, T, F, F);
        chk("pre_resume_tick", 32'(cnt_p), 13);

        // Overflow on the prescaled counter, leave it mid-prescale, then reset between edges.
        cycle(T, 8'd255, F, F, F, F);
        for (int k = 0; k < 3; k++) cycle(F, 8'd0, T, T, F, F);
        chk("pre_wrap_of", 32'({cnt_p, of_v[2], err_v[2]}), 32'({8'd0, 1'b1, 1'b1}));
        cycle(F, 8'd0, T, T, F, F);
        #3;
        clear = 1'b0;
        model_reset();
        #1;
        check_reset_state("async");
        #2;
        clear = 1'b1;
        cycle(F, 8'd0, T, T, F, F);
        cycle(F, 8'd0, T, T, F, F);
        chk("post_rst_no_tick", 32'(cnt_p), 0);
        cycle(F, 8'd0, T, T, F, F);
        chk("post_rst_full_prescale", 32'(cnt_p), 1);

        // Downward prescaled steps and saturation at zero.
        cycle(T, 8'd1, F, F, F, F);
        for (int k = 0; k < 6; k++) cycle(F, 8'd0, T, F, T, F);
        chk("sat_zero_hold", 32'(cnt_s), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
Parametrised successor to the 16-bit up/down counter. Adds configurable width, a programmable modulus, wrap or saturate mode, a clock-enable prescaler, separate overflow/underflow pulses and a sticky error flag. It is a drop-in general counter for timing, event-count and address-generation datapaths in the lab designs.

Parameters:
WIDTH, 16, counter and dataIn width in bits; legal range 2..32.
MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; must be >= 1 and <= 2**WIDTH-1.
SAT_MODE, 0, 0 = wrap at the boundaries, 1 = saturate at the boundaries.
PRESCALE, 1, number of enabled cycles per count step; must be >= 1; 1 = step every enabled cycle.

Ports:
CLK  input  1  rising-edge clock.
clear  input  1  asynchronous active-low reset.
dataIn  input  WIDTH  parallel load value.
load  input  1  synchronous load; highest synchronous priority.
enable  input  1  count enable; gates the prescaler and stepping.
up  input  1  count-up request.
down  input  1  count-down request.
ackErr  input  1  clears errFlag.
A_count  output  WIDTH  current count (registered).
oFlow  output  1  one-cycle pulse: an up step hit the upper boundary.
uFlow  output  1  one-cycle pulse: a down step hit the lower boundary.
errFlag  output  1  sticky; set by any oFlow/uFlow event.
atMax  output  1  combinational, A_count == MAX_VAL.
atZero  output  1  combinational, A_count == 0.

Behaviour:
- Reset (clear=0, asynchronous): A_count=0, internal prescaler=0, oFlow=0, uFlow=0, errFlag=0. Takes effect immediately. A reset mid-count discards any partial prescale.
- Synchronous priority on each rising CLK edge: load > step > hold.
- Load: A_count <= min(dataIn, MAX_VAL), i.e. values above MAX_VAL clamp to MAX_VAL. The prescaler is reset to 0. oFlow and uFlow are 0 that cycle. enable, up and down are ignored.
- Direction: dir_valid = up XOR down. The cases up=down=1 and up=down=0 are hold.
- Prescaler: advances only when enable=1 and dir_valid=1, counting 0..PRESCALE-1. A tick occurs in the cycle the prescaler equals PRESCALE-1; the prescaler then returns to 0. When enable=0 or dir_valid=0, the prescaler holds its value and is not cleared. With PRESCALE=1 every qualifying cycle is a tick.
- Step on tick, up:
  - If A_count < MAX_VAL: A_count+1.
  - If A_count == MAX_VAL: oFlow=1 for one cycle. A_count becomes 0 if SAT_MODE=0, or stays at MAX_VAL if SAT_MODE=1.
- Step on tick, down:
  - If A_count > 0: A_count-1.
  - If A_count == 0: uFlow=1 for one cycle. A_count becomes MAX_VAL if SAT_MODE=0, or stays at 0 if SAT_MODE=1.
- oFlow and uFlow are registered and assert in the same edge that updates A_count (latency 1 from the tick cycle). They deassert on the next edge unless another boundary tick occurs. They are never high simultaneously.
- errFlag: set on any edge where oFlow or uFlow is being set. Cleared on an edge with ackErr=1 and no new event; a new event wins when both occur on the same edge. errFlag holds otherwise and is unaffected by load.
- atMax and atZero are decoded from the registered A_count. With MAX_VAL=1 both are exclusive and valid.
- Arithmetic is WIDTH bits unsigned with no intermediate overflow. The comparison against MAX_VAL uses a WIDTH-bit constant.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SAT_MODE=0, PRESCALE=1. Load 8, then up+enable for 3 cycles -> A_count 9, 0, 1; oFlow high exactly on the edge producing 0; errFlag=1 afterwards.
2. Same configuration. Load 0, then down+enable for 1 cycle -> A_count=9, uFlow one-cycle pulse. Then ackErr=1 -> errFlag=0 next edge. Then ackErr=1 together with a down step from 0 -> errFlag stays 1.
3. SAT_MODE=1, MAX_VAL=9. Load 15 -> A_count=9 (clamped), atMax=1. Up for 2 cycles -> A_count stays 9, oFlow pulses on each of the 2 edges.
4. PRESCALE=3, WIDTH=8, MAX_VAL=255. Load 10, then up+enable for 7 cycles -> A_count=12. Drop enable for 2 cycles mid-sequence -> steps delayed by exactly 2 cycles, no prescale loss. up=down=1 -> hold, prescaler frozen.
5. Assert load=1 with up=1 at A_count=MAX_VAL -> dataIn loaded, no oFlow.
6. Pull clear low asynchronously between edges while mid-prescale with errFlag=1 -> all outputs 0 immediately. After release, the first tick requires a full PRESCALE qualifying cycles.
